// File: rtl/decoder_lut.sv
// rtl/decoder_lut.sv - Truth-table masked N_IN-input decoder with registered valid/ready output
// Any N_IN-input Boolean function: one-hot decode of in_data selects one bit of a writable truth table.
module decoder_lut #(
   parameter int                  N_IN    = 2,
   parameter logic [2**N_IN-1:0]  INIT_TT = 4'b0111,
   parameter int                  CNT_W   = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 cfg_wr,
   input  logic [N_IN-1:0]      cfg_addr,
   input  logic                 cfg_data,
   input  logic                 in_valid,
   input  logic [N_IN-1:0]      in_data,
   output logic                 in_ready,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic                 out_y,
   output logic [2**N_IN-1:0]   out_onehot,
   output logic [CNT_W-1:0]     txn_cnt
);

   localparam int W = 2**N_IN;

   logic [W-1:0] tt;
   logic [W-1:0] onehot;
   logic         accept;
   logic         consume;

   assign in_ready = !out_valid || out_ready;
   assign accept   = in_valid && in_ready;
   assign consume  = out_valid && out_ready;
   assign onehot   = {{(W-1){1'b0}}, 1'b1} << in_data;

   always_ff @(posedge clk) begin
      if (rst) begin
         tt <= INIT_TT;
      end else if (cfg_wr) begin
         tt[cfg_addr] <= cfg_data;
      end
   end

   // The result samples tt before any same-edge cfg_wr lands.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid  <= 1'b0;
         out_y      <= 1'b0;
         out_onehot <= '0;
      end else if (accept) begin
         out_valid  <= 1'b1;
         out_y      <= |(onehot & tt);
         out_onehot <= onehot;
      end else if (consume) begin
         out_valid  <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         txn_cnt <= '0;
      end else if (consume) begin
         txn_cnt <= txn_cnt + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_decoder_lut.sv
// tb/tb_decoder_lut.sv - Scoreboard bench for decoder_lut
// Expected results are queued at the accepting edge and compared while the output is held.
module tb_decoder_lut;

   localparam int         N_IN  = 2;
   localparam int         W     = 4;
   localparam int         CNT_W = 4;
   localparam logic [3:0] INIT  = 4'b0111;

   logic             clk = 1'b0;
   logic             rst;
   logic             cfg_wr;
   logic [N_IN-1:0]  cfg_addr;
   logic             cfg_data;
   logic             in_valid;
   logic [N_IN-1:0]  in_data;
   logic             in_ready;
   logic             out_valid;
   logic             out_ready;
   logic             out_y;
   logic [W-1:0]     out_onehot;
   logic [CNT_W-1:0] txn_cnt;

   int n_tests = 0;
   int n_fail  = 0;

   logic [4:0]       sb[$];
   logic             m_valid;
   logic [CNT_W-1:0] m_cnt;
   logic [3:0]       m_tt;
   logic [3:0]       v;

   decoder_lut #(.N_IN(N_IN), .INIT_TT(INIT), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst), .cfg_wr(cfg_wr), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
      .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
      .out_valid(out_valid), .out_ready(out_ready), .out_y(out_y),
      .out_onehot(out_onehot), .txn_cnt(txn_cnt)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   always @(negedge clk) begin
      logic consumed;
      if (rst) begin
         m_valid = 1'b0;
         m_cnt   = '0;
         m_tt    = INIT;
         sb.delete();
      end else begin
         check("in_ready", 32'(in_ready), 32'(!m_valid || out_ready));
         check("out_valid", 32'(out_valid), 32'(m_valid));
         check("txn_cnt", 32'(txn_cnt), 32'(m_cnt));
         if (m_valid) begin
            check("sb_nonempty", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
               check("out_y", 32'(out_y), 32'(sb[0][4]));
               check("out_onehot", 32'(out_onehot), 32'(sb[0][3:0]));
            end
         end
         consumed = m_valid && out_ready;
         if (consumed) begin
            if (sb.size() != 0) void'(sb.pop_front());
            m_cnt = m_cnt + 1'b1;
         end
         if (in_valid && (!m_valid || out_ready)) begin
            sb.push_back({m_tt[in_data], 4'b0001 << in_data});
            m_valid = 1'b1;
         end else if (consumed) begin
            m_valid = 1'b0;
         end
         if (cfg_wr) m_tt[cfg_addr] = cfg_data;
      end
   end

   initial begin
      rst = 1'b1; cfg_wr = 1'b0; cfg_addr = '0; cfg_data = 1'b0;
      in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
      step(); step();
      @(negedge clk);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_out_y", 32'(out_y), 32'd0);
      check("rst_out_onehot", 32'(out_onehot), 32'd0);
      check("rst_txn_cnt", 32'(txn_cnt), 32'd0);
      check("rst_in_ready", 32'(in_ready), 32'd1);
      step();
      rst = 1'b0;

      // default NAND table, back-to-back
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         in_valid = 1'b1; in_data = 2'(i); step();
      end
      in_valid = 1'b0;
      step(); step();
      @(negedge clk);
      check("dflt_cnt", 32'(txn_cnt), 32'd4);
      step();

      // reprogram to NOT of MSB
      v = 4'b0011;
      for (int i = 0; i < 4; i++) begin
         cfg_wr = 1'b1; cfg_addr = 2'(i); cfg_data = v[i]; step();
      end
      cfg_wr = 1'b0;
      in_valid = 1'b1; in_data = 2'd0; step();
      in_data = 2'd2; step();
      in_valid = 1'b0;
      step(); step();

      // backpressure
      out_ready = 1'b0;
      in_valid = 1'b1; in_data = 2'd3; step();
      in_data = 2'd0; step(); step();
      @(negedge clk);
      check("bp_out_y", 32'(out_y), 32'd0);
      check("bp_onehot", 32'(out_onehot), 32'h8);
      check("bp_in_ready", 32'(in_ready), 32'd0);
      check("bp_cnt", 32'(txn_cnt), 32'd6);
      step();
      out_ready = 1'b1;
      step();
      in_valid = 1'b0;
      step(); step();
      @(negedge clk);
      check("bp_cnt_after", 32'(txn_cnt), 32'd8);
      step();

      // cfg_wr on the accepting edge does not affect that result
      in_valid = 1'b1; in_data = 2'd1;
      cfg_wr = 1'b1; cfg_addr = 2'd1; cfg_data = 1'b0;
      step();
      cfg_wr = 1'b0;
      @(negedge clk);
      check("same_edge_old", 32'(out_y), 32'd1);
      step();
      in_valid = 1'b0;
      @(negedge clk);
      check("same_edge_new", 32'(out_y), 32'd0);
      step(); step();

      // counter wrap at CNT_W=4
      rst = 1'b1; step(); rst = 1'b0;
      for (int i = 0; i < 17; i++) begin
         in_valid = 1'b1; in_data = 2'($urandom_range(0, 3)); step();
      end
      in_valid = 1'b0;
      step(); step();
      @(negedge clk);
      check("wrap_cnt", 32'(txn_cnt), 32'd1);
      step();

      // reset while a result is held
      cfg_wr = 1'b1; cfg_addr = 2'd3; cfg_data = 1'b1; step();
      cfg_wr = 1'b0;
      out_ready = 1'b0;
      in_valid = 1'b1; in_data = 2'd2; step();
      in_valid = 1'b0;
      @(negedge clk);
      check("mid_held", 32'(out_valid), 32'd1);
      step();
      rst = 1'b1; step(); rst = 1'b0;
      @(negedge clk);
      check("mid_out_valid", 32'(out_valid), 32'd0);
      check("mid_cnt", 32'(txn_cnt), 32'd0);
      check("mid_in_ready", 32'(in_ready), 32'd1);
      step();
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         in_valid = 1'b1; in_data = 2'(i); step();
         if (i == 3) begin
            @(negedge clk);
            check("mid_tt3", 32'(out_y), 32'd0);
         end
      end
      in_valid = 1'b0;
      step(); step();
      @(negedge clk);
      check("mid_final_cnt", 32'(txn_cnt), 32'd4);
      check("sb_drained", 32'(sb.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
